multicycle_ctrl_fsm: RTL and testbench

- Multi-cycle control sequencer for the RISC-V core: FETCH -> DECODE -> EXEC -> MEM -> WB.
- Drives the shared datapath: PC, IR, ALU, register file, immediate generator and data memory port.
- Selects the immediate format and issues memory request/ready handshakes.
- Counts retired instructions and traps on unsupported opcodes.

---
 rtl/multicycle_ctrl_fsm.sv | 221 ++++++++++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl_fsm.sv
// rtl/multicycle_ctrl_fsm.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer
//
// Purpose: steps the shared RISC-V datapath through one instruction at a time,
// selects the immediate format, handshakes with instruction/data memory,
// counts retired instructions and traps on unsupported opcodes.
// Optional build macro: MEM_TIMEOUT_EN (memory-wait watchdog + bus_error port).
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   instr               IR contents (opcode in [6:0])
//   alu_zero            ALU zero flag, used for BEQ in EXEC
//   imem_ready          instruction memory data valid
//   dmem_ready          data memory ready
//   imem_req, ir_write  fetch request / IR latch strobe
//   pc_write, pc_src    PC commit strobe / 0 = PC+4, 1 = branch target
//   imm_type            0 = I, 1 = S, 2 = B, 3 = U, 7 = none
//   alu_src_a/b, alu_op ALU operand selects and operation class
//   dmem_req, dmem_we   data memory request / write enable
//   reg_write, wb_sel   register write strobe / 0 = ALU, 1 = memory data
//   illegal             sticky unsupported-opcode flag
//   bus_error           sticky memory timeout flag (MEM_TIMEOUT_EN only)
//   state               current state for debug
//   retire_count        retired instruction counter (wraps)
module multicycle_ctrl_fsm #(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] instr,
  input  logic                  alu_zero,
  input  logic                  imem_ready,
  input  logic                  dmem_ready,
  output logic                  imem_req,
  output logic                  ir_write,
  output logic                  pc_write,
  output logic                  pc_src,
  output logic [2:0]            imm_type,
  output logic                  alu_src_a,
  output logic                  alu_src_b,
  output logic [1:0]            alu_op,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic                  reg_write,
  output logic                  wb_sel,
  output logic                  illegal,
`ifdef MEM_TIMEOUT_EN
  output logic                  bus_error,
`endif
  output logic [2:0]            state,
  output logic [DATA_WIDTH-1:0] retire_count
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    C_OPIMM, C_AUIPC, C_LOAD, C_STORE, C_RTYPE, C_BRANCH
  } cls_t;

  localparam logic [2:0] IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2,
                         IMM_U = 3'd3, IMM_NONE = 3'd7;

  state_t                state_q, state_d;
  cls_t                  cls_q, cls_d;
  logic [2:0]            imm_type_q, imm_type_d;
  logic                  illegal_q, illegal_d;
  logic [DATA_WIDTH-1:0] retire_count_q, retire_count_d;

  // Only the opcode field steers control; upper IR bits belong to the datapath.
  logic unused_instr_hi;
  assign unused_instr_hi = ^instr[DATA_WIDTH-1:7];

  logic       dec_legal;
  cls_t       dec_cls;
  logic [2:0] dec_imm;

  always_comb begin
    dec_legal = 1'b1;
    dec_cls   = C_RTYPE;
    dec_imm   = IMM_NONE;
    case (instr[6:0])
      7'b0010011: begin dec_cls = C_OPIMM;  dec_imm = IMM_I; end
      7'b0010111: begin dec_cls = C_AUIPC;  dec_imm = IMM_U; end
      7'b0000011: begin dec_cls = C_LOAD;   dec_imm = IMM_I; end
      7'b0100011: begin dec_cls = C_STORE;  dec_imm = IMM_S; end
      7'b0110011: begin dec_cls = C_RTYPE;  dec_imm = IMM_NONE; end
      7'b1100011: begin dec_cls = C_BRANCH; dec_imm = IMM_B; end
      default:    dec_legal = 1'b0;
    endcase
  end

  logic in_fetch, in_exec, in_mem, in_wb;
  assign in_fetch = (state_q == S_FETCH);
  assign in_exec  = (state_q == S_EXEC);
  assign in_mem   = (state_q == S_MEM);
  assign in_wb    = (state_q == S_WB);

  // Reset parks the FSM in FETCH; the request is held off until reset releases.
  assign imem_req  = in_fetch && rst_n;
  assign ir_write  = imem_req && imem_ready;
  assign dmem_req  = in_mem;
  assign dmem_we   = in_mem && (cls_q == C_STORE);
  assign reg_write = in_wb;
  assign wb_sel    = in_wb && (cls_q == C_LOAD);

  assign alu_src_a = in_exec && (cls_q == C_AUIPC);
  assign alu_src_b = in_exec && (cls_q inside {C_OPIMM, C_AUIPC, C_LOAD, C_STORE});
  always_comb begin
    alu_op = 2'b00;
    if (in_exec) begin
      if (cls_q == C_OPIMM || cls_q == C_RTYPE) alu_op = 2'b10;
      else if (cls_q == C_BRANCH)               alu_op = 2'b01;
    end
  end

  // Exactly one commit point per instruction class.
  assign pc_write = in_wb
                 || (in_mem  && (cls_q == C_STORE) && dmem_ready)
                 || (in_exec && (cls_q == C_BRANCH));
  assign pc_src   = in_exec && (cls_q == C_BRANCH) && alu_zero;

  logic timeout_hit;

`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic          bus_error_q, bus_error_d;
  logic          waiting;

  assign waiting     = (in_fetch && !imem_ready) || (in_mem && !dmem_ready);
  assign timeout_hit = waiting && (wait_cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign bus_error   = bus_error_q;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d        = state_q;
    cls_d          = cls_q;
    imm_type_d     = imm_type_q;
    illegal_d      = illegal_q;
    retire_count_d = retire_count_q;
    case (state_q)
      S_FETCH: begin
        if (imem_ready)       state_d = S_DECODE;
        else if (timeout_hit) state_d = S_TRAP;
      end
      S_DECODE: begin
        if (dec_legal) begin
          state_d    = S_EXEC;
          cls_d      = dec_cls;
          imm_type_d = dec_imm;
        end else begin
          illegal_d = 1'b1;
          state_d   = S_TRAP;
        end
      end
      S_EXEC: begin
        case (cls_q)
          C_BRANCH:       state_d = S_FETCH;
          C_LOAD, C_STORE: state_d = S_MEM;
          default:        state_d = S_WB;
        endcase
      end
      S_MEM: begin
        if (dmem_ready)       state_d = (cls_q == C_LOAD) ? S_WB : S_FETCH;
        else if (timeout_hit) state_d = S_TRAP;
      end
      S_WB:    state_d = S_FETCH;
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
    if (pc_write) retire_count_d = retire_count_q + DATA_WIDTH'(1);
  end

`ifdef MEM_TIMEOUT_EN
  always_comb begin
    wait_cnt_d  = '0;
    bus_error_d = bus_error_q || timeout_hit;
    if (state_d == state_q && waiting) wait_cnt_d = wait_cnt_q + CW'(1);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_FETCH;
      cls_q          <= C_RTYPE;
      imm_type_q     <= IMM_NONE;
      illegal_q      <= 1'b0;
      retire_count_q <= '0;
`ifdef MEM_TIMEOUT_EN
      wait_cnt_q     <= '0;
      bus_error_q    <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      cls_q          <= cls_d;
      imm_type_q     <= imm_type_d;
      illegal_q      <= illegal_d;
      retire_count_q <= retire_count_d;
`ifdef MEM_TIMEOUT_EN
      wait_cnt_q     <= wait_cnt_d;
      bus_error_q    <= bus_error_d;
`endif
    end
  end

  assign imm_type     = imm_type_q;
  assign illegal      = illegal_q;
  assign state        = state_q;
  assign retire_count = retire_count_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb/tb_multicycle_ctrl_fsm.sv - self-checking bench for multicycle_ctrl_fsm
module tb_multicycle_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        alu_zero, imem_ready, dmem_ready;
  logic        imem_req, ir_write, pc_write, pc_src;
  logic [2:0]  imm_type;
  logic        alu_src_a, alu_src_b;
  logic [1:0]  alu_op;
  logic        dmem_req, dmem_we, reg_write, wb_sel, illegal;
  logic [2:0]  state;
  logic [31:0] retire_count;
`ifdef MEM_TIMEOUT_EN
  logic        bus_error;
`endif

  always #5 clk = ~clk;

  multicycle_ctrl_fsm #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .alu_zero(alu_zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .imm_type(imm_type), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .reg_write(reg_write), .wb_sel(wb_sel),
    .illegal(illegal),
`ifdef MEM_TIMEOUT_EN
    .bus_error(bus_error),
`endif
    .state(state), .retire_count(retire_count)
  );

  typedef struct {
    logic [31:0] instr;
    logic        az;
    int          wait_n;   // MEM cycles with dmem_ready low before it rises
    logic [31:0] trace;    // one nibble per cycle: state sequence up to commit
    logic [2:0]  imm;
    logic        a;
    logic        b;
    logic [1:0]  op;
    logic        pc_src;
    int          rw;
    logic        wb_sel;
    logic        we;
    int          dreq;
  } vec_t;

  localparam int NV = 9;
  vec_t vecs [NV];
  vec_t sb [$];

  int n_vec = 0;
  int n_bad = 0;
  logic [31:0] exp_retire = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    vec_t        e;
    int          mem_cyc = 0, dreq_n = 0, rw_n = 0, iw_n = 0;
    logic        we_seen = 1'b0, done = 1'b0;
    logic [31:0] trace = 0;
    sb.push_back(v);
    instr    = v.instr;
    alu_zero = v.az;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      imem_ready = 1'b1;
      dmem_ready = (mem_cyc >= v.wait_n);
      #1;
      trace = (trace << 4) | {29'd0, state};
      if (state == 3'd3) begin
        mem_cyc++;
        dreq_n += int'(dmem_req);
        we_seen |= dmem_we;
      end
      rw_n += int'(reg_write);
      iw_n += int'(ir_write);
      if (state == 3'd2) begin
        e = sb[0];
        chk("exec_imm_type", {29'd0, imm_type}, {29'd0, e.imm});
        chk("exec_alu_src_a", {31'd0, alu_src_a}, {31'd0, e.a});
        chk("exec_alu_src_b", {31'd0, alu_src_b}, {31'd0, e.b});
        chk("exec_alu_op", {30'd0, alu_op}, {30'd0, e.op});
      end
      if (pc_write) begin
        done = 1'b1;
        e = sb.pop_front();
        chk("state_trace", trace, e.trace);
        chk("pc_src", {31'd0, pc_src}, {31'd0, e.pc_src});
        chk("wb_sel", {31'd0, wb_sel}, {31'd0, e.wb_sel});
        chk("reg_write_pulses", rw_n, e.rw);
        chk("ir_write_pulses", iw_n, 1);
        chk("dmem_we_seen", {31'd0, we_seen}, {31'd0, e.we});
        chk("dmem_req_cycles", dreq_n, e.dreq);
      end
    end
    if (!done) begin
      chk("commit_timeout", 0, 1);
      if (sb.size() > 0) void'(sb.pop_front());
    end
    @(posedge clk);
    #1;
    if (done) exp_retire = exp_retire + 1;
    chk("retire_count", retire_count, exp_retire);
    chk("pc_write_single", {31'd0, pc_write}, 0);
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    logic [2:0] st3;
    int         pw_n, rw_n;
    logic       found;

    //          instr         az    wait trace          imm   a     b     op     pcs   rw wbs   we    dreq
    vecs[0] = '{32'h00500093, 1'b0, 0, 32'h00000124, 3'd0, 1'b0, 1'b1, 2'b10, 1'b0, 1, 1'b0, 1'b0, 0};
    vecs[1] = '{32'h00002103, 1'b0, 3, 32'h01233334, 3'd0, 1'b0, 1'b1, 2'b00, 1'b0, 1, 1'b1, 1'b0, 4};
    vecs[2] = '{32'h00112023, 1'b0, 0, 32'h00000123, 3'd1, 1'b0, 1'b1, 2'b00, 1'b0, 0, 1'b0, 1'b1, 1};
    vecs[3] = '{32'h00000463, 1'b1, 0, 32'h00000012, 3'd2, 1'b0, 1'b0, 2'b01, 1'b1, 0, 1'b0, 1'b0, 0};
    vecs[4] = '{32'h00000463, 1'b0, 0, 32'h00000012, 3'd2, 1'b0, 1'b0, 2'b01, 1'b0, 0, 1'b0, 1'b0, 0};
    vecs[5] = '{32'h00000117, 1'b0, 0, 32'h00000124, 3'd3, 1'b1, 1'b1, 2'b00, 1'b0, 1, 1'b0, 1'b0, 0};
    vecs[6] = '{32'h002081b3, 1'b0, 0, 32'h00000124, 3'd7, 1'b0, 1'b0, 2'b10, 1'b0, 1, 1'b0, 1'b0, 0};
    vecs[7] = '{32'h00112023, 1'b0, 2, 32'h00012333, 3'd1, 1'b0, 1'b1, 2'b00, 1'b0, 0, 1'b0, 1'b1, 3};
    vecs[8] = '{32'h00002103, 1'b0, 0, 32'h00001234, 3'd0, 1'b0, 1'b1, 2'b00, 1'b0, 1, 1'b1, 1'b0, 1};

    rst_n = 1'b0; instr = 32'd0; alu_zero = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_state", {29'd0, state}, 0);
    chk("rst_retire", retire_count, 0);
    chk("rst_illegal", {31'd0, illegal}, 0);
    chk("rst_imm_type", {29'd0, imm_type}, 7);
    chk("rst_imem_req", {31'd0, imem_req}, 0);
    chk("rst_dmem_req", {31'd0, dmem_req}, 0);
    chk("rst_pc_write", {31'd0, pc_write}, 0);
    chk("rst_reg_write", {31'd0, reg_write}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) run_vec(vecs[i]);

    // Unsupported opcode: TRAP right after DECODE, absorbing, no commit.
    instr = 32'hFFFFFFFF;
    pw_n = 0; rw_n = 0; st3 = 3'd0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      imem_ready = 1'b1;
      dmem_ready = 1'b1;
      #1;
      if (k == 2) st3 = state;
      pw_n += int'(pc_write);
      rw_n += int'(reg_write);
    end
    chk("trap_after_decode", {29'd0, st3}, 5);
    chk("trap_state_held", {29'd0, state}, 5);
    chk("trap_illegal", {31'd0, illegal}, 1);
    chk("trap_pc_writes", pw_n, 0);
    chk("trap_reg_writes", rw_n, 0);
    chk("trap_retire", retire_count, exp_retire);
    chk("trap_imem_req", {31'd0, imem_req}, 0);
    chk("trap_dmem_req", {31'd0, dmem_req}, 0);

    @(negedge clk);
    rst_n = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    #1;
    chk("trap_rst_illegal", {31'd0, illegal}, 0);
    chk("trap_rst_state", {29'd0, state}, 0);
    exp_retire = 0;
    @(negedge clk);
    rst_n = 1'b1;

    // Reset asserted mid-MEM of a load.
    run_vec(vecs[0]);
    instr = 32'h00002103;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      imem_ready = 1'b1;
      dmem_ready = 1'b0;
      #1;
      if (state == 3'd3 && dmem_req) found = 1'b1;
    end
    chk("mid_mem_reached", {31'd0, found}, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_dmem_req", {31'd0, dmem_req}, 0);
    chk("mid_rst_state", {29'd0, state}, 0);
    chk("mid_rst_retire", retire_count, 0);
    exp_retire = 0;
    imem_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(vecs[0]);

`ifdef MEM_TIMEOUT_EN
    @(negedge clk);
    rst_n = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    #1;
    chk("to_rst_bus_error", {31'd0, bus_error}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      #1;
      if (k == 15) chk("to_still_fetch", {29'd0, state}, 0);
      if (k == 16) begin
        chk("to_trap_state", {29'd0, state}, 5);
        chk("to_bus_error", {31'd0, bus_error}, 1);
        chk("to_imem_req", {31'd0, imem_req}, 0);
      end
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
